multi_interval_timer: RTL and testbench



---
 rtl/multi_interval_timer_pkg.sv | 24 ++
 rtl/multi_interval_timer_channel.sv | 125 ++++++++++++
 rtl/multi_interval_timer.sv | 93 +++++++++
 tb/tb_multi_interval_timer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_interval_timer_pkg.sv
`timescale 1ns/1ps
// multi_interval_timer_pkg
// Shared constants for the multi-channel interval timer: the per-channel
// register offsets (low 4 address bits) and the bit positions inside the
// STATUS and CONTROL registers.
package multi_interval_timer_pkg;

  // Register offsets inside one channel's 16-word window.
  localparam logic [3:0] OFF_STATUS  = 4'd0;
  localparam logic [3:0] OFF_CONTROL = 4'd1;
  localparam logic [3:0] OFF_PERIOD0 = 4'd2;  // PERIOD words 0..3 at 2..5
  localparam logic [3:0] OFF_SNAP0   = 4'd6;  // SNAP words 0..3 at 6..9

  // CONTROL bits. START and STOP are write-only strobes.
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // STATUS bits.
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

endpackage

// File: rtl/multi_interval_timer_channel.sv
`timescale 1ns/1ps
// timer_channel
// One down-counter channel: period, counter, snapshot, CONTROL flags
// (ITO, CONT) and STATUS flags (TO, RUN).
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   i_wr_en           bus write addressed to this channel
//   i_off             register offset within the channel window
//   i_wdata           write data
//   o_rdata           combinational read slice for i_off
//   o_irq             TO && ITO
module timer_channel #(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h005F5E0F,
  parameter bit          RESET_RUN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_wr_en,
  input  logic [3:0]  i_off,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_irq
);
  import multi_interval_timer_pkg::*;

  localparam int NW = CNT_W / 16;
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_snap;
  logic             r_force;
  logic             r_to;
  logic             r_run;
  logic             r_ito;
  logic             r_cont;

  logic             w_wr_status;
  logic             w_wr_control;
  logic [NW-1:0]    w_wr_period;
  logic [NW-1:0]    w_wr_snap;
  logic             w_timeout;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_wr_status  = i_wr_en && (i_off == OFF_STATUS);
    w_wr_control = i_wr_en && (i_off == OFF_CONTROL);
    w_wr_period  = '0;
    w_wr_snap    = '0;
    // Words at or above CNT_W/16 are not decoded, so writes there vanish.
    for (int k = 0; k < NW; k++) begin
      w_wr_period[k] = i_wr_en && (i_off == OFF_PERIOD0 + 4'(k));
      w_wr_snap[k]   = i_wr_en && (i_off == OFF_SNAP0 + 4'(k));
    end
  end

  assign w_timeout = r_run && (r_count == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; r_snap below relies on this to capture the
  // count before this edge's decrement.
  // NOTE: period, counter and snapshot are ordinary flops, not a RAM, so
  // they take the async reset like the rest of the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= RST_PERIOD;
      r_count  <= RST_PERIOD;
      r_snap   <= '0;
      r_force  <= 1'b0;
    end else begin
      // A period write reloads the counter one edge later, with the new value.
      r_force <= |w_wr_period;
      for (int k = 0; k < NW; k++) begin
        if (w_wr_period[k]) r_period[16*k +: 16] <= i_wdata;
      end
      if (|w_wr_snap) r_snap <= r_count;
      // Zero always reloads, so the decrement never wraps.
      if (r_force || w_timeout) r_count <= r_period;
      else if (r_run)           r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to   <= 1'b0;
      r_run  <= RESET_RUN;
      r_ito  <= 1'b0;
      r_cont <= 1'b1;
    end else begin
      // A timeout beats a concurrent STATUS write clearing TO.
      if (w_timeout)        r_to <= 1'b1;
      else if (w_wr_status) r_to <= 1'b0;

      if (w_wr_control) begin
        r_ito  <= i_wdata[CTL_ITO];
        r_cont <= i_wdata[CTL_CONT];
      end

      // STOP beats START; both beat the timeout's RUN <= CONT.
      if (w_wr_control && i_wdata[CTL_STOP])       r_run <= 1'b0;
      else if (w_wr_control && i_wdata[CTL_START]) r_run <= 1'b1;
      else if (w_timeout)                          r_run <= r_cont;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_off == OFF_STATUS) begin
      o_rdata[ST_TO]  = r_to;
      o_rdata[ST_RUN] = r_run;
    end else if (i_off == OFF_CONTROL) begin
      o_rdata[CTL_ITO]  = r_ito;
      o_rdata[CTL_CONT] = r_cont;
    end
    for (int k = 0; k < NW; k++) begin
      if (i_off == OFF_PERIOD0 + 4'(k)) o_rdata = r_period[16*k +: 16];
      if (i_off == OFF_SNAP0 + 4'(k))   o_rdata = r_snap[16*k +: 16];
    end
  end

  assign o_irq = r_to && r_ito;

endmodule

// File: rtl/multi_interval_timer.sv
`timescale 1ns/1ps
// multi_interval_timer
// NUM_CH independent CNT_W-bit interval timers behind one 16-bit
// Avalon-MM slave with a registered, 1-cycle read path.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   address            {channel, 4-bit register offset}
//   chipselect/write_n bus write qualifier
//   read_n             unused; readdata tracks address every cycle
//   writedata          write data
//   readdata           registered read data
//   irq                OR of irq_vec
//   irq_vec            per-channel TO && ITO
module multi_interval_timer #(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h005F5E0F,
  parameter bit          RESET_RUN    = 1'b1,
  localparam int         AW           = $clog2(NUM_CH) + 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);
  import multi_interval_timer_pkg::*;

  localparam int CH_W = (AW > 4) ? AW - 4 : 1;

  logic [CH_W-1:0]   w_ch;
  logic [3:0]        w_off;
  logic              w_wr;
  logic [15:0]       w_rdata [NUM_CH];
  logic [15:0]       w_rd_mux;
  logic [NUM_CH-1:0] w_irq_vec;
  logic [15:0]       r_readdata;
  logic              w_unused_read_n;

  // Reads have no side effects, so read_n carries no information here.
  assign w_unused_read_n = read_n;

  generate
    if (AW > 4) begin : g_ch_sel
      assign w_ch = address[AW-1:4];
    end else begin : g_single_ch
      assign w_ch = '0;
    end
  endgenerate

  assign w_off = address[3:0];
  assign w_wr  = chipselect && !write_n;

  // Channel numbers without an instance never match, so they read 0 and
  // ignore writes.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_channel #(
      .CNT_W       (CNT_W),
      .RESET_PERIOD(RESET_PERIOD),
      .RESET_RUN   (RESET_RUN)
    ) u_channel (
      .clk    (clk),
      .reset_n(reset_n),
      .i_wr_en(w_wr && (w_ch == CH_W'(c))),
      .i_off  (w_off),
      .i_wdata(writedata),
      .o_rdata(w_rdata[c]),
      .o_irq  (w_irq_vec[c])
    );
  end

  always_comb begin
    w_rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == CH_W'(c)) w_rd_mux = w_rdata[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign irq_vec  = w_irq_vec;
  assign irq      = |w_irq_vec;

endmodule

// File: tb/tb_multi_interval_timer.sv
`timescale 1ns/1ps
// Directed bench for multi_interval_timer: a 2-channel 32-bit instance and a
// 3-channel 64-bit instance share clock, reset and bus lines; each has its
// own chipselect. Bus ops start at a falling edge and take one cycle.
module tb_multi_interval_timer;
  import multi_interval_timer_pkg::*;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic [5:0]  address   = '0;
  logic        chipselect = 1'b0;
  logic        cs_w      = 1'b0;
  logic        write_n   = 1'b1;
  logic        read_n    = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [15:0] readdata_w;
  logic        irq;
  logic        irq_w;
  logic [1:0]  irq_vec;
  logic [2:0]  irq_vec_w;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_interval_timer #(
    .NUM_CH(2), .CNT_W(32), .RESET_PERIOD(32'h005F5E0F), .RESET_RUN(1'b1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address[4:0]),
    .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
    .writedata(writedata), .readdata(readdata), .irq(irq), .irq_vec(irq_vec)
  );

  multi_interval_timer #(
    .NUM_CH(3), .CNT_W(64), .RESET_PERIOD(32'h005F5E0F), .RESET_RUN(1'b1)
  ) u_wide (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs_w), .write_n(write_n), .read_n(read_n),
    .writedata(writedata), .readdata(readdata_w), .irq(irq_w), .irq_vec(irq_vec_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ad(input int ch, input int off);
    return 6'(ch * 16 + off);
  endfunction

  task automatic bus_write(input bit wide, input logic [5:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = !wide;
    cs_w       = wide;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    cs_w       = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input bit wide, input logic [5:0] a, output logic [15:0] d);
    address    = a;
    chipselect = !wide;
    cs_w       = wide;
    read_n     = 1'b0;
    @(negedge clk);
    d          = wide ? readdata_w : readdata;
    chipselect = 1'b0;
    cs_w       = 1'b0;
    read_n     = 1'b1;
  endtask

  // Returns the cycle number at which irq_vec[idx] is first seen high.
  task automatic wait_irq(input int idx, output int t);
    bit found = 1'b0;
    t = 0;
    for (int i = 0; i < 64; i++) begin
      if (irq_vec[idx]) begin
        found = 1'b1;
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("irq_wait_ch%0d", idx), 64'(found), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] exp_w [4];
    bit found;
    int t1, t2, t3, s, t;

    // ---------------- reset ----------------
    #1 reset_n = 1'b0;
    #1;
    check("rst_readdata", 64'(readdata), 64'h0);
    check("rst_readdata_w", 64'(readdata_w), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_irq_vec", 64'(irq_vec), 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    bus_read(0, ad(0, OFF_STATUS), rd);  check("rst_status", 64'(rd), 64'h2);
    bus_read(0, ad(0, OFF_CONTROL), rd); check("rst_control", 64'(rd), 64'h2);
    bus_read(0, ad(0, 2), rd);           check("rst_period_w0", 64'(rd), 64'h5E0F);
    bus_read(0, ad(0, 3), rd);           check("rst_period_w1", 64'(rd), 64'h005F);
    bus_read(0, ad(0, 4), rd);           check("rst_period_w2_absent", 64'(rd), 64'h0);
    bus_read(0, ad(0, 6), rd);           check("rst_snap_w0", 64'(rd), 64'h0);
    bus_read(1, ad(0, 3), rd);           check("w64_rst_period_w1", 64'(rd), 64'h005F);
    bus_read(1, ad(0, 4), rd);           check("w64_rst_period_w2", 64'(rd), 64'h0);

    // ---------------- ch0 continuous, period 4 ----------------
    bus_write(0, ad(0, 3), 16'h0000);
    bus_write(0, ad(0, 2), 16'h0004);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_read(0, ad(0, OFF_STATUS), rd);
      if (rd[ST_TO]) begin
        found = 1'b1;
        break;
      end
    end
    check("p4_to_set", 64'(found), 64'd1);
    check("p4_status", 64'(rd), 64'h3);
    check("p4_irq_masked", 64'(irq), 64'h0);

    bus_write(0, ad(0, OFF_CONTROL), 16'h0003);
    check("ito_irq", 64'(irq), 64'h1);
    check("ito_irq_vec", 64'(irq_vec), 64'h1);

    // Clear TO away from a timeout edge, then time consecutive timeouts.
    for (int i = 0; i < 3; i++) begin
      bus_write(0, ad(0, OFF_STATUS), 16'h0000);
      if (!irq_vec[0]) break;
    end
    wait_irq(0, t1);
    bus_write(0, ad(0, OFF_STATUS), 16'h0000);
    check("clr_to", 64'(irq_vec[0]), 64'h0);
    wait_irq(0, t2);
    check("p4_interval_1", 64'(t2 - t1), 64'd5);
    check("p4_irq", 64'(irq), 64'h1);
    bus_write(0, ad(0, OFF_STATUS), 16'h0000);
    wait_irq(0, t3);
    check("p4_interval_2", 64'(t3 - t2), 64'd5);
    bus_write(0, ad(0, OFF_CONTROL), 16'h0002);
    check("ito_off_irq", 64'(irq), 64'h0);

    // ---------------- ch1 one-shot, period 3 ----------------
    bus_write(0, ad(1, OFF_CONTROL), 16'h0008);
    bus_write(0, ad(1, 3), 16'h0000);
    bus_write(0, ad(1, 2), 16'h0003);
    bus_write(0, ad(1, OFF_CONTROL), 16'h0005);
    s = cyc;
    wait_irq(1, t);
    check("os_latency", 64'(t - s), 64'd4);
    check("os_irq", 64'(irq), 64'h1);
    bus_read(0, ad(1, OFF_STATUS), rd);  check("os_status", 64'(rd), 64'h1);
    bus_write(0, ad(1, 6), 16'h0000);
    bus_read(0, ad(1, 6), rd);           check("os_snap_w0", 64'(rd), 64'h3);
    bus_read(0, ad(1, 7), rd);           check("os_snap_w1", 64'(rd), 64'h0);
    bus_write(0, ad(1, OFF_STATUS), 16'h0000);
    repeat (12) @(negedge clk);
    check("os_no_repeat", 64'(irq_vec[1]), 64'h0);
    bus_write(0, ad(1, OFF_CONTROL), 16'h0005);
    s = cyc;
    wait_irq(1, t);
    check("os_restart_latency", 64'(t - s), 64'd4);
    bus_read(0, ad(1, OFF_STATUS), rd);  check("os_restart_status", 64'(rd), 64'h1);

    // ---------------- ch0 period 0, set beats clear ----------------
    bus_write(0, ad(0, OFF_CONTROL), 16'h0003);
    bus_write(0, ad(0, 2), 16'h0000);
    @(negedge clk);
    bus_write(0, ad(0, OFF_STATUS), 16'h0000);
    check("set_wins", 64'(irq_vec[0]), 64'h1);
    bus_write(0, ad(0, 6), 16'h0000);
    bus_read(0, ad(0, 6), rd);           check("p0_snap", 64'(rd), 64'h0);
    bus_read(0, ad(0, OFF_STATUS), rd);  check("p0_status", 64'(rd), 64'h3);

    // ---------------- START|STOP, unused offsets ----------------
    bus_write(0, ad(1, OFF_CONTROL), 16'h0006);
    bus_read(0, ad(1, OFF_STATUS), rd);  check("start_run", 64'(rd[ST_RUN]), 64'h1);
    bus_write(0, ad(1, OFF_CONTROL), 16'h000E);
    bus_read(0, ad(1, OFF_STATUS), rd);  check("startstop_run", 64'(rd[ST_RUN]), 64'h0);
    bus_read(0, ad(1, OFF_CONTROL), rd); check("startstop_control", 64'(rd), 64'h2);

    bus_write(0, ad(0, 12), 16'hFFFF);
    bus_read(0, ad(0, 12), rd);          check("unused_off", 64'(rd), 64'h0);
    bus_write(0, ad(0, 4), 16'h1234);
    bus_read(0, ad(0, 4), rd);           check("absent_word", 64'(rd), 64'h0);
    bus_read(0, ad(0, 2), rd);           check("unused_no_period_change", 64'(rd), 64'h0);
    bus_read(0, ad(0, OFF_CONTROL), rd); check("unused_no_ctl_change", 64'(rd), 64'h3);
    bus_read(0, ad(0, OFF_STATUS), rd);  check("unused_no_run_change", 64'(rd), 64'h3);

    // ---------------- 64-bit channel ----------------
    bus_write(1, ad(0, OFF_CONTROL), 16'h000A);
    bus_write(1, ad(0, 2), 16'h1111);
    bus_write(1, ad(0, 3), 16'h2222);
    bus_write(1, ad(0, 4), 16'h3333);
    bus_write(1, ad(0, 5), 16'h4444);
    // Captured one edge after the last word write: that reload still
    // carried the period from before word 3 changed.
    bus_write(1, ad(0, 7), 16'h0000);
    exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      bus_read(1, ad(0, 6 + k), rd);
      check($sformatf("w64_reload_lag_w%0d", k), 64'(rd), 64'(exp_w[k]));
    end
    bus_write(1, ad(0, 9), 16'h0000);
    exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 4; k++) begin
      bus_read(1, ad(0, 6 + k), rd);
      check($sformatf("w64_snap_w%0d", k), 64'(rd), 64'(exp_w[k]));
    end

    bus_write(1, ad(0, OFF_CONTROL), 16'h0006);
    bus_write(1, ad(0, 2), 16'h0001);
    bus_write(1, ad(0, 3), 16'h0000);
    bus_write(1, ad(0, 4), 16'h0000);
    bus_write(1, ad(0, 5), 16'h0000);
    @(negedge clk);
    bus_write(1, ad(0, 6), 16'h0000);
    exp_w = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      bus_read(1, ad(0, 6 + k), rd);
      check($sformatf("w64_midcount_w%0d", k), 64'(rd), 64'(exp_w[k]));
    end

    bus_write(1, ad(3, OFF_CONTROL), 16'hFFFF);
    bus_read(1, ad(3, OFF_STATUS), rd);  check("w64_nochan_status", 64'(rd), 64'h0);
    bus_read(1, ad(3, 2), rd);           check("w64_nochan_period", 64'(rd), 64'h0);
    bus_read(1, ad(2, OFF_STATUS), rd);  check("w64_ch2_untouched", 64'(rd), 64'h2);

    // ---------------- async reset mid-count ----------------
    bus_read(0, ad(0, OFF_STATUS), rd);  check("pre_rst_status", 64'(rd), 64'h3);
    check("pre_rst_irq", 64'(irq), 64'h1);
    #1 reset_n = 1'b0;
    #0.5;
    check("async_rst_readdata", 64'(readdata), 64'h0);
    check("async_rst_irq", 64'(irq), 64'h0);
    check("async_rst_irq_vec", 64'(irq_vec), 64'h0);
    #0.5 reset_n = 1'b1;
    @(negedge clk);
    // One edge of counting has passed since release.
    bus_write(0, ad(0, 6), 16'h0000);
    bus_read(0, ad(0, 6), rd);           check("post_rst_snap_w0", 64'(rd), 64'h5E0E);
    bus_read(0, ad(0, 7), rd);           check("post_rst_snap_w1", 64'(rd), 64'h005F);
    bus_read(0, ad(0, OFF_STATUS), rd);  check("post_rst_status", 64'(rd), 64'h2);
    bus_read(0, ad(0, OFF_CONTROL), rd); check("post_rst_control", 64'(rd), 64'h2);
    bus_read(0, ad(0, 2), rd);           check("post_rst_period_w0", 64'(rd), 64'h5E0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
